// File: rtl/cga_rgb_encoder.sv
// CGA video output stage: RGBI pixels to RGB in fixed-RGBI, palette, mono-green or
// composite-colour modes, all sharing one 3-cycle pipeline with an output-valid strobe.
module cga_rgb_encoder #(
    parameter int unsigned COLOR_BITS = 6,
    parameter int unsigned TAPS       = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    pix_valid,
    input  logic [3:0]              video,
    input  logic                    hblank,
    input  logic [1:0]              mode,
    input  logic                    pal_we,
    input  logic [3:0]              pal_addr,
    input  logic [3*COLOR_BITS-1:0] pal_data,
    output logic [COLOR_BITS-1:0]   red,
    output logic [COLOR_BITS-1:0]   green,
    output logic [COLOR_BITS-1:0]   blue,
    output logic                    out_valid
);
    localparam int unsigned CW    = COLOR_BITS;
    localparam int unsigned PW    = 3 * COLOR_BITS;
    localparam int unsigned AW    = 20;
    localparam int unsigned K     = (TAPS == 8) ? 3 : 2;
    localparam int unsigned Y_SH  = K - 2;
    localparam int unsigned IQ_SH = K - 1;

    localparam logic [1:0] MODE_RGBI = 2'b00;
    localparam logic [1:0] MODE_PAL  = 2'b01;
    localparam logic [1:0] MODE_MONO = 2'b10;
    localparam logic [1:0] MODE_COMP = 2'b11;

    localparam int unsigned   MAX_LVL = (1 << CW) - 1;
    localparam logic [CW-1:0] LVL1    = CW'(MAX_LVL / 3);
    localparam logic [CW-1:0] LVL2    = CW'((2 * MAX_LVL) / 3);
    localparam logic [CW-1:0] LVL3    = CW'(MAX_LVL);

    localparam logic signed [AW-1:0] C255 = AW'(255);

    function automatic logic [CW-1:0] level(input logic [1:0] l);
        logic [CW-1:0] v;
        v = '0;
        case (l)
            2'd1:    v = LVL1;
            2'd2:    v = LVL2;
            2'd3:    v = LVL3;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Fixed CGA colours: bit2 red, bit1 green, bit0 blue, bit3 intensity; index 6 is brown.
    function automatic logic [PW-1:0] rgbi_entry(input logic [3:0] v);
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
        r = {v[2], v[3]};
        g = {v[1], v[3]};
        b = {v[0], v[3]};
        if (v == 4'd6) g = 2'd1;
        return {level(b), level(g), level(r)};
    endfunction

    function automatic logic [PW-1:0] mono_entry(input logic [3:0] v);
        logic [1:0] code;
        if (v == 4'd0)      code = 2'd0;
        else if (v == 4'd8) code = 2'd1;
        else if (v[3])      code = 2'd3;
        else                code = 2'd2;
        return {CW'(0), level(code), CW'(0)};
    endfunction

    // Colour-burst chroma amplitude per colour and subcarrier phase.
    function automatic logic [5:0] chroma(input logic [2:0] px, input logic [2:0] ph);
        logic [5:0] c;
        c = 6'd0;
        case (px)
            3'd1: case (ph)
                3'd3, 3'd6: c = 6'd5;
                3'd4, 3'd5: c = 6'd50;
                default:    c = 6'd0;
            endcase
            3'd2: case (ph)
                3'd0, 3'd1, 3'd6, 3'd7: c = 6'd50;
                default:                c = 6'd0;
            endcase
            3'd3: case (ph)
                3'd0, 3'd5, 3'd6, 3'd7: c = 6'd50;
                default:                c = 6'd0;
            endcase
            3'd4: case (ph)
                3'd1, 3'd2, 3'd3, 3'd4: c = 6'd50;
                default:                c = 6'd0;
            endcase
            3'd5: case (ph)
                3'd2, 3'd3, 3'd4, 3'd5: c = 6'd50;
                default:                c = 6'd0;
            endcase
            3'd6: case (ph)
                3'd0, 3'd1, 3'd7: c = 6'd50;
                3'd2:             c = 6'd40;
                3'd3:             c = 6'd15;
                default:          c = 6'd0;
            endcase
            3'd7:    c = 6'd50;
            default: c = 6'd0;
        endcase
        return c;
    endfunction

    function automatic logic signed [7:0] cos_lut(input logic [2:0] ph);
        logic signed [7:0] c;
        case (ph)
            3'd0:    c = 8'sd16;
            3'd1:    c = 8'sd53;
            3'd2:    c = 8'sd64;
            3'd3:    c = 8'sd36;
            3'd4:    c = -8'sd8;
            3'd5:    c = -8'sd50;
            3'd6:    c = -8'sd32;
            default: c = -8'sd45;
        endcase
        return c;
    endfunction

    function automatic logic signed [7:0] sin_lut(input logic [2:0] ph);
        logic signed [7:0] s;
        case (ph)
            3'd0:    s = -8'sd64;
            3'd1:    s = -8'sd32;
            3'd2:    s = 8'sd12;
            3'd3:    s = 8'sd51;
            3'd4:    s = 8'sd64;
            3'd5:    s = 8'sd40;
            3'd6:    s = 8'sd0;
            default: s = -8'sd30;
        endcase
        return s;
    endfunction

    function automatic logic [CW-1:0] clamp_trunc(input logic signed [AW-1:0] v);
        logic [7:0] c8;
        if (v[AW-1])        c8 = 8'd0;
        else if (v > C255)  c8 = 8'hFF;
        else                c8 = v[7:0];
        return c8[7 -: CW];
    endfunction

    logic [PW-1:0] pal [16];

    logic [2:0] phase;
    logic [3:0] held;
    logic [1:0] mode_q;

    logic                   s1_valid, s1_push, s1_clear;
    logic [1:0]             s1_mode;
    logic [PW-1:0]          s1_rgb;
    logic signed [AW-1:0]   s1_s;
    logic signed [7:0]      s1_cos, s1_sin;

    logic signed [AW-1:0]   hist_y [TAPS];
    logic signed [AW-1:0]   hist_i [TAPS];
    logic signed [AW-1:0]   hist_q [TAPS];
    logic signed [AW-1:0]   sum_y, sum_i, sum_q;
    logic                   s2_valid;
    logic [1:0]             s2_mode;
    logic [PW-1:0]          s2_rgb;

    logic                   s3_valid;
    logic [1:0]             s3_mode;
    logic [PW-1:0]          s3_rgb;
    logic signed [AW-1:0]   s3_y, s3_i, s3_q;

    logic [3:0]             held_nx;
    logic [6:0]             samp;
    logic [2:0]             phase_nx;
    logic [PW-1:0]          colour;
    logic signed [AW-1:0]   e_y, e_i, e_q;
    logic signed [AW-1:0]   mat_r, mat_g, mat_b;

    // Palette register file; a same-cycle read sees the entry before the write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned a = 0; a < 16; a++) pal[a] <= rgbi_entry(4'(a));
        end else if (pal_we) begin
            pal[pal_addr] <= pal_data;
        end
    end

    // Stage 1 lookups: held pixel, phase, burst sample and non-composite colour.
    always_comb begin
        held_nx  = held;
        phase_nx = phase;
        colour   = '0;
        if (pix_valid && !phase[0]) held_nx = video;
        samp = (held_nx[3] ? 7'd21 : 7'd0) + {1'b0, chroma(held_nx[2:0], phase)};
        if (hblank)         phase_nx = '0;
        else if (pix_valid) phase_nx = phase + 3'd1;
        case (mode)
            MODE_RGBI: colour = rgbi_entry(video);
            MODE_PAL:  colour = pal[video];
            MODE_MONO: colour = mono_entry(video);
            default:   colour = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase    <= '0;
            held     <= '0;
            mode_q   <= MODE_RGBI;
            s1_valid <= 1'b0;
            s1_push  <= 1'b0;
            s1_clear <= 1'b0;
            s1_mode  <= MODE_RGBI;
            s1_rgb   <= '0;
            s1_s     <= '0;
            s1_cos   <= '0;
            s1_sin   <= '0;
        end else begin
            phase    <= phase_nx;
            held     <= held_nx;
            mode_q   <= mode;
            s1_valid <= pix_valid;
            s1_push  <= pix_valid && !hblank && (mode == MODE_COMP);
            s1_clear <= (mode != mode_q);
            s1_mode  <= mode;
            s1_rgb   <= colour;
            s1_s     <= AW'(samp);
            s1_cos   <= cos_lut(phase);
            s1_sin   <= sin_lut(phase);
        end
    end

    always_comb begin
        e_y = s1_s;
        e_i = s1_s * AW'(s1_cos);
        e_q = s1_s * AW'(s1_sin);
    end

    // Stage 2: moving-sum filter kept as running totals over shift-register histories.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned t = 0; t < TAPS; t++) begin
                hist_y[t] <= '0;
                hist_i[t] <= '0;
                hist_q[t] <= '0;
            end
            sum_y <= '0;
            sum_i <= '0;
            sum_q <= '0;
        end else if (s1_clear) begin
            for (int unsigned t = 0; t < TAPS; t++) begin
                hist_y[t] <= '0;
                hist_i[t] <= '0;
                hist_q[t] <= '0;
            end
            if (s1_push) begin
                hist_y[0] <= e_y;
                hist_i[0] <= e_i;
                hist_q[0] <= e_q;
                sum_y     <= e_y;
                sum_i     <= e_i;
                sum_q     <= e_q;
            end else begin
                sum_y <= '0;
                sum_i <= '0;
                sum_q <= '0;
            end
        end else if (s1_push) begin
            hist_y[0] <= e_y;
            hist_i[0] <= e_i;
            hist_q[0] <= e_q;
            for (int unsigned t = 1; t < TAPS; t++) begin
                hist_y[t] <= hist_y[t-1];
                hist_i[t] <= hist_i[t-1];
                hist_q[t] <= hist_q[t-1];
            end
            sum_y <= sum_y + e_y - hist_y[TAPS-1];
            sum_i <= sum_i + e_i - hist_i[TAPS-1];
            sum_q <= sum_q + e_q - hist_q[TAPS-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_mode  <= MODE_RGBI;
            s2_rgb   <= '0;
            s3_valid <= 1'b0;
            s3_mode  <= MODE_RGBI;
            s3_rgb   <= '0;
            s3_y     <= '0;
            s3_i     <= '0;
            s3_q     <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_mode  <= s1_mode;
            s2_rgb   <= s1_rgb;
            s3_valid <= s2_valid;
            s3_mode  <= s2_mode;
            s3_rgb   <= s2_rgb;
            s3_y     <= sum_y >>> Y_SH;
            s3_i     <= sum_i >>> IQ_SH;
            s3_q     <= sum_q >>> IQ_SH;
        end
    end

    always_comb begin
        mat_r = s3_y + (s3_i >>> 5) + (s3_q >>> 6);
        mat_g = s3_y - (s3_i >>> 7) - (s3_q >>> 6);
        mat_b = s3_y - (s3_i >>> 5) + (s3_q >>> 4);
    end

    // Output stage; colour holds while no valid pixel arrives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= s3_valid;
            if (s3_valid) begin
                if (s3_mode == MODE_COMP) begin
                    red   <= clamp_trunc(mat_r);
                    green <= clamp_trunc(mat_g);
                    blue  <= clamp_trunc(mat_b);
                end else begin
                    {blue, green, red} <= s3_rgb;
                end
            end
        end
    end
endmodule

// File: tb/tb_cga_rgb_encoder.sv
// Bench for cga_rgb_encoder: vector table plus composite/palette/reset sequences,
// checked through a latency-tagged scoreboard against a reference model.
`timescale 1ns/1ps
module tb_cga_rgb_encoder;
    localparam int unsigned CB = 6;
    localparam int unsigned NT = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          pix_valid;
    logic [3:0]    video;
    logic          hblank;
    logic [1:0]    mode;
    logic          pal_we;
    logic [3:0]    pal_addr;
    logic [3*CB-1:0] pal_data;
    logic [CB-1:0] red, green, blue;
    logic          out_valid;

    cga_rgb_encoder #(.COLOR_BITS(CB), .TAPS(NT)) dut (
        .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .video(video),
        .hblank(hblank), .mode(mode), .pal_we(pal_we), .pal_addr(pal_addr),
        .pal_data(pal_data), .red(red), .green(green), .blue(blue),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct { logic [5:0] r, g, b; int cyc; } exp_t;
    typedef struct { logic pv; logic [1:0] m; logic [3:0] v; logic [5:0] r, g, b; } vec_t;

    exp_t sbq[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic mon_en = 1'b0;
    logic [5:0] last_r = '0, last_g = '0, last_b = '0;

    int lv[4]       = '{0, 21, 42, 63};
    int cos_t[8]    = '{16, 53, 64, 36, -8, -50, -32, -45};
    int sin_t[8]    = '{-64, -32, 12, 51, 64, 40, 0, -30};
    int burst[8][8] = '{'{0, 0, 0, 0, 0, 0, 0, 0},
                        '{0, 0, 0, 5, 50, 50, 5, 0},
                        '{50, 50, 0, 0, 0, 0, 50, 50},
                        '{50, 0, 0, 0, 0, 50, 50, 50},
                        '{0, 50, 50, 50, 50, 0, 0, 0},
                        '{0, 0, 50, 50, 50, 50, 0, 0},
                        '{50, 50, 40, 15, 0, 0, 0, 50},
                        '{50, 50, 50, 50, 50, 50, 50, 50}};

    int         m_phase;
    logic [3:0] m_held;
    logic [1:0] m_prev;
    int         hs[NT];
    int         hph[NT];
    logic [17:0] pal_m[16];

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [17:0] rgbi_m(input logic [3:0] v);
        int r, g, b;
        r = lv[{v[2], v[3]}];
        g = (v == 4'd6) ? lv[1] : lv[{v[1], v[3]}];
        b = lv[{v[0], v[3]}];
        return {6'(b), 6'(g), 6'(r)};
    endfunction

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : (v > 255) ? 255 : v;
    endfunction

    function automatic void model_reset();
        m_phase = 0;
        m_held  = '0;
        m_prev  = 2'b00;
        for (int t = 0; t < NT; t++) begin hs[t] = 0; hph[t] = 0; end
        for (int a = 0; a < 16; a++) pal_m[a] = rgbi_m(4'(a));
    endfunction

    // Reference: full sums recomputed over the whole history each pixel.
    function automatic void model_step(input logic pv, input logic [3:0] v, input logic hb,
                                       input logic [1:0] m, output logic [17:0] bgr);
        int ph, s, sy, si, sq, y, i, q, code;
        if (m != m_prev) for (int t = 0; t < NT; t++) hs[t] = 0;
        m_prev = m;
        ph = m_phase;
        if (pv && (ph % 2 == 0)) m_held = v;
        s = (m_held[3] ? 21 : 0) + burst[m_held[2:0]][ph];
        if (pv && !hb && m == 2'b11) begin
            for (int t = NT - 1; t > 0; t--) begin hs[t] = hs[t-1]; hph[t] = hph[t-1]; end
            hs[0] = s;
            hph[0] = ph;
        end
        if (hb) m_phase = 0;
        else if (pv) m_phase = (m_phase + 1) % 8;
        case (m)
            2'b00: bgr = rgbi_m(v);
            2'b01: bgr = pal_m[v];
            2'b10: begin
                code = (v == 0) ? 0 : (v == 8) ? 1 : v[3] ? 3 : 2;
                bgr = {6'd0, 6'(lv[code]), 6'd0};
            end
            default: begin
                sy = 0; si = 0; sq = 0;
                for (int t = 0; t < NT; t++) begin
                    sy += hs[t];
                    si += hs[t] * cos_t[hph[t]];
                    sq += hs[t] * sin_t[hph[t]];
                end
                y = sy >>> 1;
                i = si >>> 2;
                q = sq >>> 2;
                bgr = {6'(clamp(y - (i >>> 5) + (q >>> 4)) >> 2),
                       6'(clamp(y - (i >>> 7) - (q >>> 6)) >> 2),
                       6'(clamp(y + (i >>> 5) + (q >>> 6)) >> 2)};
            end
        endcase
    endfunction

    task automatic step(input logic pv, input logic [3:0] v, input logic hb, input logic [1:0] m,
                        input logic we, input logic [3:0] wa, input logic [17:0] wd,
                        input logic ue, input logic [5:0] xr, input logic [5:0] xg,
                        input logic [5:0] xb);
        logic [17:0] bgr;
        exp_t e;
        @(negedge clk);
        pix_valid = pv; video = v; hblank = hb; mode = m;
        pal_we = we; pal_addr = wa; pal_data = wd;
        model_step(pv, v, hb, m, bgr);
        if (pv) begin
            e.r = ue ? xr : bgr[5:0];
            e.g = ue ? xg : bgr[11:6];
            e.b = ue ? xb : bgr[17:12];
            e.cyc = cyc + 1;
            sbq.push_back(e);
        end
        if (we) pal_m[wa] = wd;
    endtask

    task automatic px(input logic pv, input logic [3:0] v, input logic hb, input logic [1:0] m);
        step(pv, v, hb, m, 1'b0, 4'd0, 18'd0, 1'b0, 6'd0, 6'd0, 6'd0);
    endtask

    task automatic pxe(input logic [3:0] v, input logic [1:0] m,
                       input logic [5:0] r, input logic [5:0] g, input logic [5:0] b);
        step(1'b1, v, 1'b0, m, 1'b0, 4'd0, 18'd0, 1'b1, r, g, b);
    endtask

    // Scoreboard monitor: each valid output is popped and its latency checked; idle cycles hold.
    always begin
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (reset_n && mon_en) begin
            if (out_valid) begin
                check("sb_pending", int'(sbq.size() != 0), 1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check("red", int'(red), int'(e.r));
                    check("green", int'(green), int'(e.g));
                    check("blue", int'(blue), int'(e.b));
                    check("latency", cyc, e.cyc + 3);
                    last_r = e.r; last_g = e.g; last_b = e.b;
                end
            end else begin
                check("hold_red", int'(red), int'(last_r));
                check("hold_green", int'(green), int'(last_g));
                check("hold_blue", int'(blue), int'(last_b));
            end
        end
    end

    vec_t vt[16];

    initial begin
        vt[0]  = '{1'b1, 2'd0, 4'h6, 6'd42, 6'd21, 6'd0};
        vt[1]  = '{1'b1, 2'd0, 4'hC, 6'd63, 6'd21, 6'd21};
        vt[2]  = '{1'b1, 2'd0, 4'hF, 6'd63, 6'd63, 6'd63};
        vt[3]  = '{1'b1, 2'd0, 4'h0, 6'd0,  6'd0,  6'd0};
        vt[4]  = '{1'b1, 2'd0, 4'h1, 6'd0,  6'd0,  6'd42};
        vt[5]  = '{1'b1, 2'd0, 4'h8, 6'd21, 6'd21, 6'd21};
        vt[6]  = '{1'b0, 2'd0, 4'hF, 6'd0,  6'd0,  6'd0};
        vt[7]  = '{1'b1, 2'd2, 4'h0, 6'd0,  6'd0,  6'd0};
        vt[8]  = '{1'b1, 2'd2, 4'h8, 6'd0,  6'd21, 6'd0};
        vt[9]  = '{1'b1, 2'd2, 4'h7, 6'd0,  6'd42, 6'd0};
        vt[10] = '{1'b1, 2'd2, 4'hF, 6'd0,  6'd63, 6'd0};
        vt[11] = '{1'b0, 2'd2, 4'h3, 6'd0,  6'd0,  6'd0};
        vt[12] = '{1'b1, 2'd1, 4'h6, 6'd42, 6'd21, 6'd0};
        vt[13] = '{1'b1, 2'd1, 4'hE, 6'd63, 6'd63, 6'd21};
        vt[14] = '{1'b1, 2'd1, 4'h5, 6'd42, 6'd0,  6'd42};
        vt[15] = '{1'b1, 2'd1, 4'hA, 6'd21, 6'd63, 6'd21};

        reset_n = 1'b0; pix_valid = 1'b0; video = '0; hblank = 1'b0; mode = 2'b00;
        pal_we = 1'b0; pal_addr = '0; pal_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_red", int'(red), 0);
        check("reset_green", int'(green), 0);
        check("reset_blue", int'(blue), 0);
        check("reset_valid", int'(out_valid), 0);
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        for (int k = 0; k < 16; k++)
            step(vt[k].pv, vt[k].v, 1'b0, vt[k].m, 1'b0, 4'd0, 18'd0, 1'b1,
                 vt[k].r, vt[k].g, vt[k].b);

        // Palette write to the index being streamed: old entry this pixel, new entry next.
        pxe(4'h3, 2'd1, 6'd0, 6'd42, 6'd42);
        step(1'b1, 4'h3, 1'b0, 2'd1, 1'b1, 4'h3, {6'd5, 6'd10, 6'd20}, 1'b1,
             6'd0, 6'd42, 6'd42);
        pxe(4'h3, 2'd1, 6'd20, 6'd10, 6'd5);
        px(1'b0, 4'h3, 1'b0, 2'd1);
        pxe(4'h3, 2'd1, 6'd20, 6'd10, 6'd5);

        // Composite white (7): ramp from cleared history, then settled at every phase.
        px(1'b1, 4'h7, 1'b1, 2'd3);
        for (int k = 0; k < 16; k++) begin
            if (k == 11) px(1'b0, 4'h7, 1'b0, 2'd3);
            if (k >= 7) pxe(4'h7, 2'd3, 6'd55, 6'd47, 6'd54);
            else        px(1'b1, 4'h7, 1'b0, 2'd3);
        end

        // Composite bright white saturates every channel.
        for (int k = 0; k < 10; k++) px(1'b1, 4'hF, 1'b0, 2'd3);
        for (int k = 0; k < 8; k++) pxe(4'hF, 2'd3, 6'd63, 6'd63, 6'd63);

        // hblank pulse, then mode 11 -> 00 -> 11 with pix_valid held high.
        px(1'b1, 4'h7, 1'b1, 2'd3);
        for (int k = 0; k < 3; k++) pxe(4'h7, 2'd0, 6'd42, 6'd42, 6'd42);
        for (int k = 0; k < 12; k++) begin
            if (k >= 7) pxe(4'h7, 2'd3, 6'd55, 6'd47, 6'd54);
            else        px(1'b1, 4'h7, 1'b0, 2'd3);
        end

        // Asynchronous reset mid-stream clears outputs at once and restores the palette.
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_red", int'(red), 0);
        check("midrst_green", int'(green), 0);
        check("midrst_blue", int'(blue), 0);
        check("midrst_valid", int'(out_valid), 0);
        mon_en = 1'b0;
        sbq.delete();
        last_r = '0; last_g = '0; last_b = '0;
        model_reset();
        @(negedge clk);
        pix_valid = 1'b0; hblank = 1'b0; mode = 2'b00; pal_we = 1'b0;
        reset_n = 1'b1;
        mon_en  = 1'b1;
        pxe(4'h6, 2'd1, 6'd42, 6'd21, 6'd0);
        pxe(4'h3, 2'd1, 6'd0, 6'd42, 6'd42);

        for (int k = 0; k < 5; k++) px(1'b0, 4'h0, 1'b0, 2'd1);
        @(negedge clk);
        check("sb_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
